// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read-port and output-stream signal bundle for fifo_rd_stream
interface fifo_rd_stream_if #(
  parameter int DATASIZE = 8
);
  // FIFO memory read port
  logic                rd_empty;
  logic [DATASIZE-1:0] rd_data;
  logic                rd_en;

  // consumer stream
  logic                out_valid;
  logic                out_ready;
  logic [DATASIZE-1:0] out_data;

  // adapter side
  modport master (
    input  rd_empty,
    input  rd_data,
    input  out_ready,
    output rd_en,
    output out_valid,
    output out_data
  );

  // memory and consumer side
  modport slave (
    output rd_empty,
    output rd_data,
    output out_ready,
    input  rd_en,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side skid buffer adapter; pop counter enabled by FIFO_RD_STREAM_CNT_EN
module fifo_rd_stream #(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 16
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  fifo_rd_stream_if.master   bus,
  output logic [CNTSIZE-1:0] rd_count
);

  // ST_HOLD covers reset and the first edge after release; ST_RUN is permanent.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          occ_q, occ_d;
  logic [1:0]          wptr_q, wptr_d;
  logic [1:0]          rptr_q, rptr_d;
  logic [DATASIZE-1:0] buf_q [3];
  logic [DATASIZE-1:0] buf_d [3];

  logic                run;
  logic                rd_en;
  logic                push;
  logic                pop;
  logic                out_valid;
  logic [2:0]          occ_sum;

  // Three-entry ring pointer: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Run state next-state: leave ST_HOLD on the first edge after reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
  end

  // Run state register.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == ST_RUN);

  // Words buffered plus the word on its way from memory; a read is only
  // issued when there is guaranteed room for its data two edges later.
  assign occ_sum   = {1'b0, occ_q} + {2'b00, inflight_q};
  assign rd_en     = run & ~bus.rd_empty & (occ_sum <= 3'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = inflight_q;
  assign pop       = out_valid & bus.out_ready;

  assign bus.rd_en     = rd_en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_q[rptr_q];

  // Buffer, pointers and occupancy next-state; rd_data is only sampled
  // when a read is in flight so an idle (possibly floating) bus is never stored.
  always_comb begin
    buf_d      = buf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    inflight_d = rd_en;
    if (push) begin
      buf_d[wptr_q] = bus.rd_data;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer, pointers and occupancy registers; everything in flight is dropped on reset.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNTSIZE-1:0] cnt_q, cnt_d;

  // Accepted-word counter next-state; wraps naturally at the counter width.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = cnt_q + CNTSIZE'(1);
    end
  end

  // Accepted-word counter register; cleared only by reset.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a queue-based FIFO memory model
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
`ifdef FIFO_RD_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] rd_count;

  fifo_rd_stream_if #(.DATASIZE(DW)) bus ();

  fifo_rd_stream #(.DATASIZE(DW), .CNTSIZE(CW)) dut (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .bus      (bus),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] exp_q[$];
  logic        rd_fire     = 1'b0;
  logic        force_empty = 1'b0;
  int          ready_sel   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: memory model answers the read sampled last cycle, then sample the new rd_en.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_fire) begin
      check("read_from_nonempty", mem_q.size() != 0, 1'b1);
      if (mem_q.size() != 0) bus.rd_data = mem_q.pop_front();
    end else begin
      bus.rd_data = 'z;
    end
    bus.rd_empty = (mem_q.size() == 0) || force_empty;
    case (ready_sel)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    rd_fire = bus.rd_en;
  endtask

  // Monitor: scoreboard, accept counter, hold stability, occupancy bound.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  int unsigned   pop_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v  = 1'b0;
      pop_cnt = 0;
    end else begin
      check("occ_plus_inflight_le3", (int'(dut.occ_q) + int'(dut.inflight_q)) <= 3, 1'b1);
      check("rd_count", rd_count, CNT_EN ? CW'(pop_cnt) : '0);
      if (hold_v) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, hold_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.out_data, 'x);
        else check("out_data", bus.out_data, exp_q.pop_front());
        pop_cnt++;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic en_h [24];
  logic ov_h [24];

  initial begin
    int first_en, last_en, n_en, first_ov, last_ov, n_ov, n, found;
    bus.rd_empty  = 1'b1;
    bus.rd_data   = 'z;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state with data waiting in the FIFO
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    bus.rd_empty  = 1'b0;
    ready_sel     = 1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("reset_rd_en", bus.rd_en, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_data", bus.out_data, '0);
    check("reset_rd_count", rd_count, '0);

    // Release and 16-word burst
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    rd_fire = bus.rd_en;
    en_h[0] = bus.rd_en;
    ov_h[0] = bus.out_valid;
    for (int c = 1; c < 24; c++) begin
      tick();
      en_h[c] = bus.rd_en;
      ov_h[c] = bus.out_valid;
      if (c == 8) begin
        check("steady_occ", dut.occ_q, 2'd1);
        check("steady_inflight", dut.inflight_q, 1'b1);
      end
    end
    first_en = -1; last_en = -1; n_en = 0;
    first_ov = -1; last_ov = -1; n_ov = 0;
    for (int c = 0; c < 24; c++) begin
      if (en_h[c]) begin if (first_en < 0) first_en = c; last_en = c; n_en++; end
      if (ov_h[c]) begin if (first_ov < 0) first_ov = c; last_ov = c; n_ov++; end
    end
    check("first_cycle_rd_en", en_h[0], 1'b0);
    check("first_rd_en_cycle", first_en, 1);
    check("rd_en_run", (n_en == 16) && (last_en - first_en == 15), 1'b1);
    check("first_out_valid_cycle", first_ov, first_en + 2);
    check("out_valid_run", (n_ov == 16) && (last_ov - first_ov == 15), 1'b1);
    check("burst_rd_count", rd_count, CNT_EN ? CW'(16) : '0);
    check("burst_all_delivered", exp_q.size(), 0);

    // Consumer stall while streaming, then release
    for (int i = 0; i < 30; i++) push_word(DW'($urandom));
    repeat (6) tick();
    ready_sel = 0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.rd_en) n++;
    end
    check("stall_extra_reads_le2", n <= 2, 1'b1);
    check("stall_occ", dut.occ_q, 2'd3);
    check("stall_inflight", dut.inflight_q, 1'b0);
    check("stall_rd_en", bus.rd_en, 1'b0);
    ready_sel = 1;
    repeat (4) tick();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid && bus.rd_en) n++;
    end
    check("resume_full_rate", n, 8);
    drain("stall_drain", 200);

    // Random ready with rd_empty toggling every cycle
    for (int i = 0; i < 40; i++) push_word(DW'($urandom));
    ready_sel = 2;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      force_empty = ~force_empty;
      tick();
      n++;
    end
    check("random_drain", exp_q.size(), 0);
    force_empty = 1'b0;
    ready_sel   = 1;
    repeat (3) tick();

    // Reset with occ=2 and a read in flight
    for (int i = 0; i < 10; i++) push_word(DW'($urandom));
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (dut.occ_q == 2'd1 && dut.inflight_q) found = 1;
    end
    check("reach_steady", found, 1);
    ready_sel = 0;
    found = 0;
    for (int c = 0; c < 5 && found == 0; c++) begin
      tick();
      if (dut.occ_q == 2'd2 && dut.inflight_q) found = 1;
    end
    check("reach_occ2_inflight", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_rd_en", bus.rd_en, 1'b0);
    check("async_rst_rd_count", rd_count, '0);
    mem_q.delete();
    exp_q.delete();
    rd_fire      = 1'b0;
    bus.rd_data  = 'z;
    bus.rd_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(8'hA0 + i));
    ready_sel = 1;
    drain("post_reset_drain", 100);
    repeat (3) tick();
    check("post_reset_rd_count", rd_count, CNT_EN ? CW'(8) : '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
